// File: rtl/fp_pkg.sv
// Shared constants, state encoding and field layout for the single-precision accumulator.
package fp_pkg;

  localparam int unsigned EXP_W       = 8;
  localparam int unsigned FRAC_W      = 23;
  localparam int unsigned MAN_W       = FRAC_W + 1;        // mantissa with hidden 1
  localparam int unsigned SUM_W       = MAN_W + 1;         // mantissa plus carry bit
  localparam int unsigned XEXP_W      = EXP_W + 2;         // exponent with overflow headroom
  localparam int unsigned DATA_W      = 1 + EXP_W + FRAC_W;
  localparam int unsigned FP_BIAS     = 127;
  localparam int unsigned EXP_SAT     = 2 * FP_BIAS + 1;   // all-ones exponent
  localparam int unsigned SHIFT_CLAMP = 25;                // alignment shift that always yields 0

  localparam logic [DATA_W-1:0] FP_ZERO = '0;
  localparam logic [EXP_W-1:0]  EXP_MAX = EXP_W'(EXP_SAT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  // Saturated magnitude with the given sign.
  function automatic fp_t fp_sat(input logic sign);
    fp_t r;
    r.sign = sign;
    r.exp  = EXP_MAX;
    r.frac = '0;
    return r;
  endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Term stream in, sum stream out, both valid/ready.
interface fp_accumulator_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fp_align.sv
// Unpack both operands, order them by magnitude and align the smaller mantissa.
module fp_align
  import fp_pkg::*;
(
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_opb,
  output logic              o_sign_a,
  output logic              o_sign_b,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MAN_W-1:0]  o_man_a,
  output logic [MAN_W-1:0]  o_man_b
);

  fp_t              w_a;
  fp_t              w_b;
  logic             w_a_zero;
  logic             w_b_zero;
  logic [EXP_W-1:0] w_exp_a;
  logic [EXP_W-1:0] w_exp_b;
  logic [MAN_W-1:0] w_man_a;
  logic [MAN_W-1:0] w_man_b;
  logic             w_swap;
  logic [EXP_W-1:0] w_exp_small;
  logic [MAN_W-1:0] w_man_small;
  logic [EXP_W-1:0] w_diff;

  assign w_a = fp_t'(i_acc);
  assign w_b = fp_t'(i_opb);

  // A zero operand contributes no mantissa and borrows the other exponent so it never drives alignment.
  assign w_a_zero = (w_a.exp == '0);
  assign w_b_zero = (w_b.exp == '0);
  assign w_exp_a  = w_a_zero ? w_b.exp : w_a.exp;
  assign w_exp_b  = w_b_zero ? w_a.exp : w_b.exp;
  assign w_man_a  = w_a_zero ? '0 : {1'b1, w_a.frac};
  assign w_man_b  = w_b_zero ? '0 : {1'b1, w_b.frac};

  // Larger exponent goes to A; on a tie the larger mantissa so A - B is never negative.
  assign w_swap = (w_exp_b > w_exp_a) || ((w_exp_b == w_exp_a) && (w_man_b > w_man_a));

  assign o_sign_a    = w_swap ? w_b.sign : w_a.sign;
  assign o_sign_b    = w_swap ? w_a.sign : w_b.sign;
  assign o_exp       = w_swap ? w_exp_b  : w_exp_a;
  assign o_man_a     = w_swap ? w_man_b  : w_man_a;
  assign w_exp_small = w_swap ? w_exp_a  : w_exp_b;
  assign w_man_small = w_swap ? w_man_a  : w_man_b;

  assign w_diff  = o_exp - w_exp_small;
  assign o_man_b = (w_diff >= EXP_W'(SHIFT_CLAMP)) ? '0 : (w_man_small >> w_diff);

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle truncating single-precision accumulator: ALIGN, ADD, then iterative NORM per term.
module fp_accumulator
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  fp_accumulator_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_acc,      w_acc_nxt;
  logic [DATA_W-1:0]   r_opb,      w_opb_nxt;
  logic                r_last,     w_last_nxt;
  logic                r_sign_a,   w_sign_a_nxt;
  logic                r_sign_b,   w_sign_b_nxt;
  logic [XEXP_W-1:0]   r_exp,      w_exp_nxt;
  logic [MAN_W-1:0]    r_man_a,    w_man_a_nxt;
  logic [MAN_W-1:0]    r_man_b,    w_man_b_nxt;
  logic [SUM_W-1:0]    r_man,      w_man_nxt;
  logic                r_sign,     w_sign_nxt;
  logic                r_in_ready, w_in_ready_nxt;
  logic                r_out_valid, w_out_valid_nxt;

  logic                w_al_sign_a;
  logic                w_al_sign_b;
  logic [EXP_W-1:0]    w_al_exp;
  logic [MAN_W-1:0]    w_al_man_a;
  logic [MAN_W-1:0]    w_al_man_b;
  logic [XEXP_W-1:0]   w_exp_inc;
  logic                w_done;

  fp_align u_align (
    .i_acc    (r_acc),
    .i_opb    (r_opb),
    .o_sign_a (w_al_sign_a),
    .o_sign_b (w_al_sign_b),
    .o_exp    (w_al_exp),
    .o_man_a  (w_al_man_a),
    .o_man_b  (w_al_man_b)
  );

  assign w_exp_inc = r_exp + XEXP_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_opb_nxt    = r_opb;
    w_last_nxt   = r_last;
    w_sign_a_nxt = r_sign_a;
    w_sign_b_nxt = r_sign_b;
    w_exp_nxt    = r_exp;
    w_man_a_nxt  = r_man_a;
    w_man_b_nxt  = r_man_b;
    w_man_nxt    = r_man;
    w_sign_nxt   = r_sign;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_opb_nxt   = bus.in_data;
          w_last_nxt  = bus.in_last;
          w_state_nxt = ST_ALIGN;
        end
      end

      ST_ALIGN: begin
        w_sign_a_nxt = w_al_sign_a;
        w_sign_b_nxt = w_al_sign_b;
        w_exp_nxt    = XEXP_W'(w_al_exp);
        w_man_a_nxt  = w_al_man_a;
        w_man_b_nxt  = w_al_man_b;
        w_state_nxt  = ST_ADD;
      end

      ST_ADD: begin
        if (r_sign_a == r_sign_b) w_man_nxt = {1'b0, r_man_a} + {1'b0, r_man_b};
        else                      w_man_nxt = {1'b0, r_man_a} - {1'b0, r_man_b};
        w_sign_nxt  = r_sign_a;
        w_state_nxt = ST_NORM;
      end

      ST_NORM: begin
        if (r_man == '0) begin
          w_acc_nxt = FP_ZERO;
          w_done    = 1'b1;
        end else if (r_man[SUM_W-1]) begin
          // Carry out: shift right with truncation, bump exponent, saturate on overflow.
          if (w_exp_inc >= XEXP_W'(EXP_SAT)) w_acc_nxt = fp_sat(r_sign);
          else w_acc_nxt = {r_sign, w_exp_inc[EXP_W-1:0], r_man[MAN_W-1:1]};
          w_done = 1'b1;
        end else if (r_man[MAN_W-1]) begin
          w_acc_nxt = {r_sign, r_exp[EXP_W-1:0], r_man[FRAC_W-1:0]};
          w_done    = 1'b1;
        end else if (r_exp <= XEXP_W'(1)) begin
          // Exponent would underflow before the leading one is found.
          w_acc_nxt = FP_ZERO;
          w_done    = 1'b1;
        end else begin
          w_man_nxt = r_man << 1;
          w_exp_nxt = r_exp - XEXP_W'(1);
        end
        if (w_done) w_state_nxt = r_last ? ST_OUT : ST_IDLE;
      end

      ST_OUT: begin
        if (r_out_valid && bus.out_ready) begin
          w_acc_nxt   = FP_ZERO;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_OUT);
  end

  // Accumulator, working registers and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= FP_ZERO;
      r_opb       <= '0;
      r_last      <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_exp       <= '0;
      r_man_a     <= '0;
      r_man_b     <= '0;
      r_man       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_opb       <= w_opb_nxt;
      r_last      <= w_last_nxt;
      r_sign_a    <= w_sign_a_nxt;
      r_sign_b    <= w_sign_b_nxt;
      r_exp       <= w_exp_nxt;
      r_man_a     <= w_man_a_nxt;
      r_man_b     <= w_man_b_nxt;
      r_man       <= w_man_nxt;
      r_sign      <= w_sign_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_acc;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed vectors for fp_accumulator: sums, latencies, backpressure and mid-sum reset.
module tb_fp_accumulator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fp_accumulator_if bus ();

  fp_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          n;
    logic [31:0] t0;
    logic [31:0] t1;
    int          lat0;
    logic [31:0] res;
    int          lat_last;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, expv);
    end
  endtask

  // Present one term and count edges from the accept edge until in_ready (or out_valid for last).
  task automatic send(input string name, input logic [31:0] d, input logic last, output int lat);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.in_ready) chk({name, " wait in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    lat = 0;
    while (lat < 60 && !(last ? bus.out_valid : bus.in_ready)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept the pending sum and confirm the return to idle on that same edge.
  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, " out_valid after hs"}, 32'(bus.out_valid), 32'd0);
    chk({name, " in_ready after hs"},  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{"single3",  1, 32'h40400000, 32'h0,          3, 32'h40400000, 3};
    vecs[1] = '{"carry",    2, 32'h3FC00000, 32'h40200000, 3, 32'h40800000, 3};
    vecs[2] = '{"cancel",   2, 32'h3F800000, 32'hBF800000, 3, 32'h00000000, 3};
    vecs[3] = '{"norm2",    2, 32'h3F800000, 32'hBF400000, 3, 32'h3E800000, 5};
    vecs[4] = '{"farB",     2, 32'h3F800000, 32'h30800000, 3, 32'h3F800000, 3};
    vecs[5] = '{"negsingle",1, 32'hBFC00000, 32'h0,          3, 32'hBFC00000, 3};

    #12;
    chk("rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data",  bus.out_data,       32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].n == 2) begin
        send(vecs[i].name, vecs[i].t0, 1'b0, lat);
        chk({vecs[i].name, " lat0"}, 32'(lat), 32'(vecs[i].lat0));
        send(vecs[i].name, vecs[i].t1, 1'b1, lat);
      end else begin
        send(vecs[i].name, vecs[i].t0, 1'b1, lat);
      end
      chk({vecs[i].name, " lat_last"}, 32'(lat), 32'(vecs[i].lat_last));
      chk({vecs[i].name, " sum"}, bus.out_data, vecs[i].res);
      drain(vecs[i].name);
    end

    // Backpressure: sum held, input blocked, stray in_valid ignored.
    send("bp", 32'h40400000, 1'b1, lat);
    chk("bp lat", 32'(lat), 32'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp out_data c%0d", c), bus.out_data, 32'h40400000);
      chk($sformatf("bp out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    drain("bp");

    // Reset in the middle of normalisation discards the partial sum.
    send("rst", 32'h3F800000, 1'b0, lat);
    chk("rst lat0", 32'(lat), 32'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hBF400000;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-norm out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid-norm in_ready",  32'(bus.in_ready),  32'd0);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("async rst out_data",  bus.out_data,       32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send("post rst", 32'h40000000, 1'b1, lat);
    chk("post rst lat", 32'(lat), 32'd3);
    chk("post rst sum", bus.out_data, 32'h40000000);
    drain("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
